// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and control-bundle layout.
// Bit positions, ALU op codes and bubble-counter states.
package mips_pkg;

  localparam int CTRL_W = 16;

  localparam int REG_DST    = 15;
  localparam int REG_WRITE  = 14;
  localparam int MEM_TO_REG = 13;
  localparam int JUMP       = 12;
  localparam int JMP_LINK   = 11;
  localparam int MEM_READ   = 10;
  localparam int MEM_WRITE  = 9;
  localparam int BR_EQ      = 8;
  localparam int BR_NE      = 7;
  localparam int ALU_SRC    = 6;
  localparam int FLOAT_OP   = 5;
  localparam int IS_SIGNED  = 4;
  localparam int ALU_OP_HI  = 3;
  localparam int ALU_OP_LO  = 0;

  typedef enum logic [3:0] {
    ALU_RTYPE = 4'h2,
    ALU_OR    = 4'h3,
    ALU_ADD   = 4'h4,
    ALU_AND   = 4'h5,
    ALU_SUB   = 4'h7,
    ALU_LUI   = 4'hb
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       jmp_link;
    logic       mem_read;
    logic       mem_write;
    logic       br_eq;
    logic       br_ne;
    logic       alu_src;
    logic       float_op;
    logic       is_signed;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef enum logic [0:0] {
    BC_IDLE = 1'b0,
    BC_HOLD = 1'b1
  } bc_state_e;

  function automatic logic ctrl_mem_read(
    input logic [CTRL_W-1:0] c
  );
    return c[MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs, EX-side registered outputs.
// master drives the ID side, slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  import mips_pkg::*;

  logic [CTRL_W-1:0] ID_Ctrl;
  logic              ID_Valid;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;
  logic [DATA_W-1:0] ID_Imm;
  logic [DATA_W-1:0] ID_PC4;
  logic [4:0]        ID_Rs;
  logic [4:0]        ID_Rt;
  logic [4:0]        ID_Rd;
  logic              ID_UsesRt;
  logic              Flush;

  logic              Stall;
  logic              PC_Write;
  logic              IFID_Write;
  logic [CTRL_W-1:0] EX_Ctrl;
  logic              EX_Valid;
  logic [DATA_W-1:0] EX_ReadData1;
  logic [DATA_W-1:0] EX_ReadData2;
  logic [DATA_W-1:0] EX_Imm;
  logic [DATA_W-1:0] EX_PC4;
  logic [4:0]        EX_Rs;
  logic [4:0]        EX_Rt;
  logic [4:0]        EX_Rd;
  logic [31:0]       StallCount;

  modport master (
    output ID_Ctrl, ID_Valid,
    output ID_ReadData1, ID_ReadData2,
    output ID_Imm, ID_PC4,
    output ID_Rs, ID_Rt, ID_Rd,
    output ID_UsesRt, Flush,
    input  Stall, PC_Write, IFID_Write,
    input  EX_Ctrl, EX_Valid,
    input  EX_ReadData1, EX_ReadData2,
    input  EX_Imm, EX_PC4,
    input  EX_Rs, EX_Rt, EX_Rd,
    input  StallCount
  );

  modport slave (
    input  ID_Ctrl, ID_Valid,
    input  ID_ReadData1, ID_ReadData2,
    input  ID_Imm, ID_PC4,
    input  ID_Rs, ID_Rt, ID_Rd,
    input  ID_UsesRt, Flush,
    output Stall, PC_Write, IFID_Write,
    output EX_Ctrl, EX_Valid,
    output EX_ReadData1, EX_ReadData2,
    output EX_Imm, EX_PC4,
    output EX_Rs, EX_Rt, EX_Rd,
    output StallCount
  );

endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// Load-use hazard term: a load in EX whose destination is read in ID.
// Purely combinational; $0 is never a hazard.
module load_use_detector (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt & (ex_rt == id_rt);

  assign hazard = ex_valid
                & ex_mem_read
                & (ex_rt != 5'd0)
                & id_valid
                & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Stall is derived from EX state and ID register fields, never ID_Ctrl.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int DATA_W           = 32
) (
  input logic          Clk,
  input logic          Rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] BUB_LOAD =
    2'(LOAD_USE_BUBBLES - 1);

  bc_state_e         state_q;
  bc_state_e         state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              hazard;
  logic              stall;
  logic              ex_mem_read;

  logic [CTRL_W-1:0] ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc4_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic [31:0]       stall_cnt_q;

  assign ex_mem_read = ctrl_mem_read(ctrl_q);

  load_use_detector u_det (
    .ex_valid    (valid_q),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (rt_q),
    .id_valid    (bus.ID_Valid),
    .id_rs       (bus.ID_Rs),
    .id_rt       (bus.ID_Rt),
    .id_uses_rt  (bus.ID_UsesRt),
    .hazard      (hazard)
  );

  assign stall = ~bus.Flush
               & (hazard | (cnt_q != 2'd0));

  // Bubble counter state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= BC_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bubble counter next state: load on hazard, count down in HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.Flush) begin
      state_d = BC_IDLE;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        BC_IDLE: begin
          if (hazard) begin
            cnt_d   = BUB_LOAD;
            state_d = (BUB_LOAD != 2'd0)
                    ? BC_HOLD : BC_IDLE;
          end
        end
        BC_HOLD: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = BC_IDLE;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = BC_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Pipeline register: flush/stall insert a bubble, else capture ID.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else if (bus.Flush | stall) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= bus.ID_Valid ? bus.ID_Ctrl : '0;
      valid_q <= bus.ID_Valid;
      rd1_q   <= bus.ID_ReadData1;
      rd2_q   <= bus.ID_ReadData2;
      imm_q   <= bus.ID_Imm;
      pc4_q   <= bus.ID_PC4;
      rs_q    <= bus.ID_Rs;
      rt_q    <= bus.ID_Rt;
      rd_q    <= bus.ID_Rd;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.Stall        = stall;
  assign bus.PC_Write     = ~stall;
  assign bus.IFID_Write   = ~stall;
  assign bus.EX_Ctrl      = ctrl_q;
  assign bus.EX_Valid     = valid_q;
  assign bus.EX_ReadData1 = rd1_q;
  assign bus.EX_ReadData2 = rd2_q;
  assign bus.EX_Imm       = imm_q;
  assign bus.EX_PC4       = pc4_q;
  assign bus.EX_Rs        = rs_q;
  assign bus.EX_Rt        = rt_q;
  assign bus.EX_Rd        = rd_q;
  assign bus.StallCount   = stall_cnt_q;

endmodule
